// File: rtl/fwd_hazard_scoreboard.sv
// rtl/fwd_hazard_scoreboard.sv - EX-stage operand forwarding, load-use and long-latency hazard unit
//
// Purpose:
//   Picks, per source operand, the youngest in-flight result to forward.
//   Flags load-use hazards and tracks long-latency (div/mul) writebacks in a
//   per-register countdown scoreboard. Stall is raised while any hazard is
//   live, and stall cycles are counted with saturation.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   ex_rs         source register addresses, src i at [i*REG_AW +: REG_AW]
//   ex_rs_used    src i is actually read by the EX instruction
//   fwd_rd        destination address per forwarding stage (0 = youngest)
//   fwd_we        stage k writes a register
//   fwd_is_load   stage k holds a load
//   lat_issue     long-latency op leaves EX this cycle (ignored while stalled)
//   lat_rd        its destination register
//   lat_cycles    cycles until it reaches the regfile (0 behaves as 1)
//   forward_sel   per source: 0 = regfile, k+1 = forward from stage k
//   stall         hold IF/ID/EX and insert a bubble
//   busy_map      scoreboard pending bit per register
//   stall_cnt     saturating count of stalled cycles
module fwd_hazard_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5,
  parameter int LAT_W   = 3,
  parameter int SEL_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [NUM_SRC-1:0]        ex_rs_used,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic                      lat_issue,
  input  logic [REG_AW-1:0]         lat_rd,
  input  logic [LAT_W-1:0]          lat_cycles,
  output logic [NUM_SRC*SEL_W-1:0]  forward_sel,
  output logic                      stall,
  output logic [(1<<REG_AW)-1:0]    busy_map,
  output logic [15:0]               stall_cnt
);

  localparam int NREGS = 1 << REG_AW;

  logic [LAT_W-1:0] cnt_q [NREGS];
  logic [LAT_W-1:0] cnt_d [NREGS];
  logic             issue_en;
  logic [LAT_W-1:0] issue_val;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      busy_map[r] = (r != 0) && (cnt_q[r] != '0);
    end
  end

  // Forward select and hazard detection. Stages are scanned oldest to
  // youngest so the last hit (lowest k) is the one that sticks.
  always_comb begin : fwd_logic
    logic [REG_AW-1:0] src;
    logic              hit;
    int                win;
    forward_sel = '0;
    stall       = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src = ex_rs[i*REG_AW +: REG_AW];
      hit = 1'b0;
      win = 0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_we[k] && (fwd_rd[k*REG_AW +: REG_AW] != '0) &&
            (fwd_rd[k*REG_AW +: REG_AW] == src)) begin
          hit = 1'b1;
          win = k;
        end
      end
      if (ex_rs_used[i]) begin
        if (hit && (win == 0) && fwd_is_load[0]) begin
          // Load data is not available yet in the youngest stage.
          stall = 1'b1;
        end else if (hit) begin
          forward_sel[i*SEL_W +: SEL_W] = SEL_W'(win + 1);
        end
        // A pending long-latency write makes any forwarded copy stale.
        if (busy_map[src]) begin
          stall = 1'b1;
        end
      end
    end
  end

  // Scoreboard next state. A re-issue never shortens an outstanding wait,
  // so the older writeback cannot land after the register is seen as free.
  always_comb begin
    issue_en  = lat_issue && !stall && (lat_rd != '0);
    issue_val = (lat_cycles == '0) ? LAT_W'(1) : lat_cycles;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      if (issue_en && (lat_rd == REG_AW'(r))) begin
        cnt_d[r] = (cnt_d[r] > issue_val) ? cnt_d[r] : issue_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cnt <= 16'd0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb/tb_fwd_hazard_scoreboard.sv - directed self-checking bench for fwd_hazard_scoreboard
module tb_fwd_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ex_rs;
  logic [1:0]  ex_rs_used;
  logic [9:0]  fwd_rd;
  logic [1:0]  fwd_we;
  logic [1:0]  fwd_is_load;
  logic        lat_issue;
  logic [4:0]  lat_rd;
  logic [2:0]  lat_cycles;
  logic [3:0]  forward_sel;
  logic        stall;
  logic [31:0] busy_map;
  logic [15:0] stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  fwd_hazard_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .ex_rs       (ex_rs),
    .ex_rs_used  (ex_rs_used),
    .fwd_rd      (fwd_rd),
    .fwd_we      (fwd_we),
    .fwd_is_load (fwd_is_load),
    .lat_issue   (lat_issue),
    .lat_rd      (lat_rd),
    .lat_cycles  (lat_cycles),
    .forward_sel (forward_sel),
    .stall       (stall),
    .busy_map    (busy_map),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_rs       = '0;
    ex_rs_used  = '0;
    fwd_rd      = '0;
    fwd_we      = '0;
    fwd_is_load = '0;
    lat_issue   = 1'b0;
    lat_rd      = '0;
    lat_cycles  = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", busy_map, 32'h0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_sel", 32'(forward_sel), 32'h0);
    rst = 1'b0;
    tick();

    // MEM beats WB on the same register
    ex_rs = {5'd5, 5'd5}; ex_rs_used = 2'b11;
    fwd_rd = {5'd5, 5'd5}; fwd_we = 2'b11;
    #1;
    check("mem_beats_wb_sel", 32'(forward_sel), 32'h5);
    check("mem_beats_wb_stall", 32'(stall), 32'h0);

    // Distinct stages per source, and unused source selects regfile
    ex_rs = {5'd3, 5'd5}; fwd_rd = {5'd5, 5'd3};
    #1;
    check("split_sel", 32'(forward_sel), 32'h6);
    ex_rs_used = 2'b01;
    #1;
    check("unused_src_sel", 32'(forward_sel), 32'h2);
    fwd_we = 2'b00;
    #1;
    check("no_we_sel", 32'(forward_sel), 32'h0);

    // Load-use in stage 0, then load moves to stage 1
    idle();
    fwd_rd = {5'd0, 5'd7}; fwd_we = 2'b01; fwd_is_load = 2'b01;
    ex_rs = {5'd0, 5'd7}; ex_rs_used = 2'b01;
    #1;
    check("load_use_stall", 32'(stall), 32'h1);
    check("load_use_sel", 32'(forward_sel), 32'h0);
    tick();
    fwd_rd = {5'd7, 5'd0}; fwd_we = 2'b10; fwd_is_load = 2'b10;
    #1;
    check("load_wb_sel", 32'(forward_sel), 32'h2);
    check("load_wb_stall", 32'(stall), 32'h0);

    // Long-latency x9, 3 cycles; issue during stall is dropped
    idle();
    lat_issue = 1'b1; lat_rd = 5'd9; lat_cycles = 3'd3;
    tick();
    lat_issue = 1'b0;
    ex_rs = {5'd0, 5'd9}; ex_rs_used = 2'b01;
    #1;
    check("sb_busy9", 32'(busy_map[9]), 32'h1);
    check("sb_stall_c1", 32'(stall), 32'h1);
    lat_issue = 1'b1; lat_rd = 5'd3; lat_cycles = 3'd2;
    tick();
    lat_issue = 1'b0;
    check("issue_dropped_in_stall", 32'(busy_map[3]), 32'h0);
    fwd_rd = {5'd0, 5'd9}; fwd_we = 2'b01;
    #1;
    check("sb_stall_c2_with_fwd", 32'(stall), 32'h1);
    tick();
    check("sb_stall_c3", 32'(stall), 32'h1);
    tick();
    check("sb_stall_clear", 32'(stall), 32'h0);
    check("sb_busy9_clear", 32'(busy_map[9]), 32'h0);

    // Register 0 is never forwarded, busy or stalling
    idle();
    ex_rs = '0; ex_rs_used = 2'b11;
    fwd_rd = '0; fwd_we = 2'b11; fwd_is_load = 2'b01;
    lat_issue = 1'b1; lat_rd = 5'd0; lat_cycles = 3'd3;
    #1;
    check("x0_sel", 32'(forward_sel), 32'h0);
    check("x0_stall", 32'(stall), 32'h0);
    tick();
    check("x0_busy", busy_map, 32'h0);

    // lat_cycles = 0 acts as a one-cycle wait
    idle();
    lat_issue = 1'b1; lat_rd = 5'd6; lat_cycles = 3'd0;
    tick();
    lat_issue = 1'b0;
    check("lat0_busy", busy_map, 32'h40);
    tick();
    check("lat0_clear", busy_map, 32'h0);

    // WAW: cnt 5, reissue 2 -> 4 (busy for 4 more samples)
    lat_issue = 1'b1; lat_rd = 5'd4; lat_cycles = 3'd5;
    tick();
    lat_cycles = 3'd2;
    tick();
    lat_issue = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("waw_keep_%0d", j), 32'(busy_map[4]), 32'h1);
      tick();
    end
    check("waw_keep_done", 32'(busy_map[4]), 32'h0);

    // WAW: cnt 5, reissue 7 -> 7
    lat_issue = 1'b1; lat_rd = 5'd4; lat_cycles = 3'd5;
    tick();
    lat_cycles = 3'd7;
    tick();
    lat_issue = 1'b0;
    for (int j = 0; j < 7; j++) begin
      check($sformatf("waw_extend_%0d", j), 32'(busy_map[4]), 32'h1);
      tick();
    end
    check("waw_extend_done", 32'(busy_map[4]), 32'h0);

    // Stall counter: exact count then saturation
    idle();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    check("rst_async_cnt", 32'(stall_cnt), 32'h0);
    fwd_rd = {5'd0, 5'd7}; fwd_we = 2'b01; fwd_is_load = 2'b01;
    ex_rs = {5'd0, 5'd7}; ex_rs_used = 2'b01;
    #1;
    repeat (100) tick();
    check("stall_cnt_100", 32'(stall_cnt), 32'd100);
    repeat (65500) tick();
    check("stall_cnt_sat", 32'(stall_cnt), 32'hFFFF);

    // Async reset mid-countdown
    idle();
    lat_issue = 1'b1; lat_rd = 5'd9; lat_cycles = 3'd7;
    tick();
    lat_issue = 1'b0;
    check("pre_rst_busy", busy_map, 32'h200);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy_map, 32'h0);
    check("mid_rst_stall_cnt", 32'(stall_cnt), 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_busy", busy_map, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
